// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor.
// Computes a - b one bit per clock, LSB first, through a single full-subtractor
// cell and a borrow flop. A start/busy/done handshake frames each operation.
// Results and flags are registered and change only when an operation completes
// or on reset.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow,
   output logic             zero
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             br_q, br_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             a_sign_q, a_sign_d;
   logic             b_sign_q, b_sign_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;

   // Single full-subtractor cell acting on the current LSBs and the borrow flop.
   // diff_full is what the result register will hold once this bit is shifted
   // in; on the last bit it is the complete difference.
   logic             d_bit;
   logic             br_next;
   logic [WIDTH-1:0] diff_full;

   assign d_bit     = sa_q[0] ^ sb_q[0] ^ br_q;
   assign br_next   = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
   assign diff_full = {d_bit, res_q[WIDTH-1:1]};

   // Next-state logic: operand capture on accept, one bit per SHIFT cycle,
   // result/flag update on the transition into DONE.
   always_comb begin
      state_d  = state_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      res_d    = res_q;
      br_d     = br_q;
      cnt_d    = cnt_q;
      a_sign_d = a_sign_q;
      b_sign_d = b_sign_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            // DONE accepts a new start directly so back-to-back operations
            // sustain one result every WIDTH+1 cycles.
            if (start) begin
               state_d  = ST_SHIFT;
               sa_d     = a;
               sb_d     = b;
               res_d    = '0;
               br_d     = 1'b0;
               cnt_d    = '0;
               a_sign_d = a[WIDTH-1];
               b_sign_d = b[WIDTH-1];
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            sa_d  = {1'b0, sa_q[WIDTH-1:1]};
            sb_d  = {1'b0, sb_q[WIDTH-1:1]};
            res_d = diff_full;
            br_d  = br_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_BIT) begin
               state_d  = ST_DONE;
               diff_d   = diff_full;
               borrow_d = br_next;
               // Signed overflow: operand signs differ and the result sign
               // (the bit just produced) disagrees with the minuend sign.
               ovf_d    = (a_sign_q ^ b_sign_q) & (d_bit ^ a_sign_q);
               zero_d   = (diff_full == '0);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         sa_q     <= '0;
         sb_q     <= '0;
         res_q    <= '0;
         br_q     <= 1'b0;
         cnt_q    <= '0;
         a_sign_q <= 1'b0;
         b_sign_q <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         res_q    <= res_d;
         br_q     <= br_d;
         cnt_q    <= cnt_d;
         a_sign_q <= a_sign_d;
         b_sign_q <= b_sign_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
      end
   end

   assign busy       = (state_q == ST_SHIFT);
   assign done       = (state_q == ST_DONE);
   assign diff       = diff_q;
   assign borrow_out = borrow_q;
   assign overflow   = ovf_q;
   assign zero       = zero_q;

endmodule
